// File: rtl/ofmap_writer_pkg.sv
// ofmap_writer_pkg
//   Shared constants, FSM state type and the int8 saturation helper for the
//   ofmap write path (and later the psum path).
//   No ports: package only.
package ofmap_writer_pkg;

   localparam int ACC_W  = 21;              // signed accumulator width
   localparam int OUT_W  = 8;               // stored result width
   localparam int PACK   = 25;              // results per SRAM word
   localparam int DATA_W = PACK * OUT_W;    // 200-bit SRAM word
   localparam int ADDR_W = 6;               // SRAM word address width
   localparam int N_OUT  = 36;              // results per output map
   localparam int SHIFT  = 4;               // requantization right shift

   localparam int CNT_W  = $clog2(N_OUT + 1);
   localparam int LANE_W = $clog2(PACK);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_FLUSH,
      ST_DONE
   } state_t;

   // Clamp a signed accumulator-width value into the int8 range.
   function automatic logic signed [OUT_W-1:0] sat8(input logic signed [ACC_W-1:0] v);
      localparam logic signed [ACC_W-1:0] MAX_V = 127;
      localparam logic signed [ACC_W-1:0] MIN_V = -128;
      if (v > MAX_V) begin
         return 8'sd127;
      end else if (v < MIN_V) begin
         return -8'sd128;
      end
      return v[OUT_W-1:0];
   endfunction

endpackage

// File: rtl/ofmap_writer_requant_relu.sv
// requant_relu
//   Combinational requantization of one accumulator to int8:
//   arithmetic shift right by SHIFT, optional ReLU clamp, saturation.
//   Ports:
//     acc  in   ACC_W  signed accumulator
//     q    out  OUT_W  signed requantized result
module requant_relu
   import ofmap_writer_pkg::*;
#(
   parameter int RELU = 1
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] q
);

   logic signed [ACC_W-1:0] shifted;
   logic signed [ACC_W-1:0] clamped;

   assign shifted = acc >>> SHIFT;

   always_comb begin
      clamped = shifted;
      if ((RELU != 0) && shifted[ACC_W-1]) begin
         clamped = '0;
      end
   end

   assign q = sat8(clamped);

endmodule

// File: rtl/ofmap_writer.sv
// ofmap_writer
//   Collects requantized conv results, packs PACK int8 lanes per SRAM word
//   (lane 0 in the low byte) and writes each word to the ofmap SRAM.
//   Ports:
//     clk          in   1       clock, rising edge
//     rst_n        in   1       asynchronous reset, active low
//     start        in   1       arm for a new map (ignored unless idle)
//     base_addr    in   ADDR_W  first word address, sampled on start
//     valid        in   1       acc carries a new result
//     acc          in   ACC_W   signed accumulator result
//     sram_cs      out  1       SRAM chip select
//     sram_we      out  1       SRAM write enable
//     sram_addr    out  ADDR_W  SRAM word address
//     sram_data_o  out  DATA_W  SRAM write data
//     busy         out  1       map in progress
//     done         out  1       one-cycle pulse after the last word write
//     overflow     out  1       sticky: result arrived while not collecting
module ofmap_writer
   import ofmap_writer_pkg::*;
#(
   parameter int RELU = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic                    valid,
   input  logic signed [ACC_W-1:0] acc,
   output logic                    sram_cs,
   output logic                    sram_we,
   output logic [ADDR_W-1:0]       sram_addr,
   output logic [DATA_W-1:0]       sram_data_o,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow
);

   // A trailing partial word exists when the map size is not a multiple of PACK.
   localparam bit PARTIAL = (N_OUT % PACK) != 0;

   state_t                   state;
   logic [CNT_W-1:0]         res_cnt;
   logic [LANE_W-1:0]        lane;
   logic [ADDR_W-1:0]        word_cnt;
   logic [ADDR_W-1:0]        base;
   logic [DATA_W-1:0]        pack;
   logic [DATA_W-1:0]        word_next;
   logic signed [OUT_W-1:0]  q;
   logic                     lane_full;
   logic                     last_res;

   requant_relu #(.RELU(RELU)) u_requant (
      .acc (acc),
      .q   (q)
   );

   // Current pack register with the incoming result dropped into its lane.
   genvar gi;
   generate
      for (gi = 0; gi < PACK; gi++) begin : g_lane
         assign word_next[gi*OUT_W +: OUT_W] =
            (lane == LANE_W'(gi)) ? q : pack[gi*OUT_W +: OUT_W];
      end
   endgenerate

   assign lane_full = (lane == LANE_W'(PACK - 1));
   assign last_res  = (res_cnt == CNT_W'(N_OUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         res_cnt     <= '0;
         lane        <= '0;
         word_cnt    <= '0;
         base        <= '0;
         pack        <= '0;
         sram_cs     <= 1'b0;
         sram_we     <= 1'b0;
         sram_addr   <= '0;
         sram_data_o <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         sram_cs <= 1'b0;
         sram_we <= 1'b0;
         done    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base     <= base_addr;
                  res_cnt  <= '0;
                  lane     <= '0;
                  word_cnt <= '0;
                  pack     <= '0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_COLLECT;
               end else if (valid) begin
                  overflow <= 1'b1;
               end
            end

            ST_COLLECT: begin
               if (valid) begin
                  res_cnt <= res_cnt + 1'b1;
                  if (lane_full || last_res) begin
                     // The output data register is the second buffer: the
                     // finished word moves there while pack restarts empty,
                     // so a result arriving during the write cycle is kept.
                     sram_cs     <= 1'b1;
                     sram_we     <= 1'b1;
                     sram_addr   <= base + word_cnt;
                     sram_data_o <= word_next;
                     word_cnt    <= word_cnt + 1'b1;
                     pack        <= '0;
                     lane        <= '0;
                  end else begin
                     pack <= word_next;
                     lane <= lane + 1'b1;
                  end
                  if (last_res) begin
                     if (PARTIAL) begin
                        state <= ST_FLUSH;
                     end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end
                  end
               end
            end

            // The partial word's strobe is on the bus during this state;
            // done follows in the next cycle.
            ST_FLUSH: begin
               state <= ST_DONE;
               done  <= 1'b1;
               busy  <= 1'b0;
               if (valid) begin
                  overflow <= 1'b1;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
               if (valid) begin
                  overflow <= 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
